// File: rtl/svm_dot_stage.sv
// Streaming SVM kernel dot-product stage: per-beat lane products (stage P), framed
// accumulation with overflow handling (stage A), and a stall-aware result register.
module svm_dot_stage #(
  parameter int DATA_SIZE  = 16,
  parameter int ACCUM_SIZE = 40,
  parameter int LANES      = 2,
  parameter int SATURATE   = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         in_first,
  input  logic                         in_last,
  input  logic [LANES*DATA_SIZE-1:0]   vec,
  input  logic [LANES*DATA_SIZE-1:0]   sv,
  input  logic signed [ACCUM_SIZE-1:0] accum_in,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [ACCUM_SIZE-1:0] out_accum,
  output logic                         out_overflow,
  output logic                         proto_err
);

  localparam logic signed [ACCUM_SIZE-1:0] ACC_MAX = {1'b0, {(ACCUM_SIZE-1){1'b1}}};
  localparam logic signed [ACCUM_SIZE-1:0] ACC_MIN = {1'b1, {(ACCUM_SIZE-1){1'b0}}};

  typedef enum logic {IDLE, ACC} state_t;

  typedef struct packed {
    logic                  ovf;
    logic [ACCUM_SIZE-1:0] sum;
  } add_t;

  // Two's-complement add with overflow flag; clamps toward the operands' sign when saturating.
  function automatic add_t sat_add(input logic signed [ACCUM_SIZE-1:0] a,
                                   input logic signed [ACCUM_SIZE-1:0] b);
    add_t r;
    r.sum = a + b;
    r.ovf = (a[ACCUM_SIZE-1] == b[ACCUM_SIZE-1]) && (r.sum[ACCUM_SIZE-1] != a[ACCUM_SIZE-1]);
    if (r.ovf && (SATURATE != 0)) r.sum = a[ACCUM_SIZE-1] ? ACC_MIN : ACC_MAX;
    return r;
  endfunction

  logic                         stall;
  logic signed [DATA_SIZE-1:0]  lane_v, lane_s;
  logic signed [2*DATA_SIZE-1:0] prod;
  logic signed [ACCUM_SIZE-1:0] dot_sum;
  add_t                         add_r;

  logic                         vld_p1_q, vld_p1_d;
  logic                         first_p1_q, first_p1_d;
  logic                         last_p1_q, last_p1_d;
  logic signed [ACCUM_SIZE-1:0] psum_p1_q, psum_p1_d;
  logic signed [ACCUM_SIZE-1:0] seed_p1_q, seed_p1_d;

  state_t                       state_q, state_d;
  logic signed [ACCUM_SIZE-1:0] acc_p2_q, acc_p2_d;
  logic                         ovf_p2_q, ovf_p2_d;
  logic                         emit_p2_q, emit_p2_d;

  logic signed [ACCUM_SIZE-1:0] out_accum_q, out_accum_d;
  logic                         out_ovf_q, out_ovf_d;
  logic                         out_valid_q, out_valid_d;
  logic                         proto_err_q, proto_err_d;

  assign stall        = out_valid_q && !out_ready;
  assign in_ready     = !stall;
  assign out_valid    = out_valid_q;
  assign out_accum    = out_accum_q;
  assign out_overflow = out_ovf_q;
  assign proto_err    = proto_err_q;

  // Stage P: full-precision lane products, sign-extended and summed.
  always_comb begin
    dot_sum = '0;
    lane_v  = '0;
    lane_s  = '0;
    prod    = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_v  = vec[i*DATA_SIZE +: DATA_SIZE];
      lane_s  = sv[i*DATA_SIZE +: DATA_SIZE];
      prod    = (2*DATA_SIZE)'(lane_v) * (2*DATA_SIZE)'(lane_s);
      dot_sum = dot_sum + ACCUM_SIZE'(prod);
    end
  end

  always_comb begin
    vld_p1_d   = vld_p1_q;
    first_p1_d = first_p1_q;
    last_p1_d  = last_p1_q;
    psum_p1_d  = psum_p1_q;
    seed_p1_d  = seed_p1_q;
    if (!stall) begin
      vld_p1_d   = in_valid;
      first_p1_d = in_first;
      last_p1_d  = in_last;
      psum_p1_d  = dot_sum;
      seed_p1_d  = accum_in;
    end
  end

  // Stage A: framing FSM and accumulator; result register loads one cycle after emit.
  always_comb begin
    state_d     = state_q;
    acc_p2_d    = acc_p2_q;
    ovf_p2_d    = ovf_p2_q;
    emit_p2_d   = emit_p2_q;
    out_accum_d = out_accum_q;
    out_ovf_d   = out_ovf_q;
    out_valid_d = out_valid_q;
    proto_err_d = 1'b0;
    add_r       = '0;
    if (!stall) begin
      emit_p2_d = 1'b0;
      if (vld_p1_q) begin
        if (first_p1_q) begin
          add_r       = sat_add(seed_p1_q, psum_p1_q);
          acc_p2_d    = add_r.sum;
          ovf_p2_d    = add_r.ovf;
          proto_err_d = (state_q == ACC);
          emit_p2_d   = last_p1_q;
          state_d     = last_p1_q ? IDLE : ACC;
        end else if (state_q == IDLE) begin
          proto_err_d = 1'b1;
        end else begin
          add_r    = sat_add(acc_p2_q, psum_p1_q);
          acc_p2_d = add_r.sum;
          ovf_p2_d = ovf_p2_q | add_r.ovf;
          if (last_p1_q) begin
            emit_p2_d = 1'b1;
            state_d   = IDLE;
          end
        end
      end
      if (emit_p2_q) begin
        out_accum_d = acc_p2_q;
        out_ovf_d   = ovf_p2_q;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p1_q    <= 1'b0;
      first_p1_q  <= 1'b0;
      last_p1_q   <= 1'b0;
      psum_p1_q   <= '0;
      seed_p1_q   <= '0;
      state_q     <= IDLE;
      acc_p2_q    <= '0;
      ovf_p2_q    <= 1'b0;
      emit_p2_q   <= 1'b0;
      out_accum_q <= '0;
      out_ovf_q   <= 1'b0;
      out_valid_q <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      vld_p1_q    <= vld_p1_d;
      first_p1_q  <= first_p1_d;
      last_p1_q   <= last_p1_d;
      psum_p1_q   <= psum_p1_d;
      seed_p1_q   <= seed_p1_d;
      state_q     <= state_d;
      acc_p2_q    <= acc_p2_d;
      ovf_p2_q    <= ovf_p2_d;
      emit_p2_q   <= emit_p2_d;
      out_accum_q <= out_accum_d;
      out_ovf_q   <= out_ovf_d;
      out_valid_q <= out_valid_d;
      proto_err_q <= proto_err_d;
    end
  end

endmodule
